// File: rtl/fp32_pkg.sv
// Shared binary32 types and constants for the subtract issue path.
// Holds the operand view, operand classes and the issue record layout.
package fp32_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_SUB,
    FP_NORM,
    FP_INF,
    FP_QNAN,
    FP_SNAN
  } fp_class_e;

  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;

  typedef struct packed {
    fp32_t core_a;
    fp32_t core_b;
    logic  eff_sub;
    logic  bypass;
    fp32_t bypass_val;
    logic  invalid;
  } issue_t;

  function automatic logic is_nan(fp_class_e c);
    return (c == FP_QNAN) || (c == FP_SNAN);
  endfunction

  function automatic logic is_zero(fp_class_e c);
    return (c == FP_ZERO) || (c == FP_SUB);
  endfunction

endpackage

// File: rtl/fsub_issue_stage_if.sv
// Operand-in / issue-record-out handshake bundle of the issue stage.
// slave: stage side; master: upstream producer plus downstream consumer.
interface fsub_issue_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_op;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_core_a;
  logic [31:0] out_core_b;
  logic        out_eff_sub;
  logic        out_bypass;
  logic [31:0] out_bypass_val;
  logic        out_invalid;

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_op,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_core_a,
    output out_core_b,
    output out_eff_sub,
    output out_bypass,
    output out_bypass_val,
    output out_invalid
  );

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_op,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_core_a,
    input  out_core_b,
    input  out_eff_sub,
    input  out_bypass,
    input  out_bypass_val,
    input  out_invalid
  );

endinterface

// File: rtl/fp32_classify.sv
// Combinational binary32 classifier: x in, class and sign out.
// Ports: x (operand), cls (ZERO/SUB/NORM/INF/QNAN/SNAN), neg (sign bit).
module fp32_classify
  import fp32_pkg::*;
(
  input  fp32_t     x,
  output fp_class_e cls,
  output logic      neg
);

  logic exp_zero;
  logic exp_max;
  logic mant_zero;

  assign exp_zero  = (x.exp == 8'h00);
  assign exp_max   = (x.exp == EXP_MAX);
  assign mant_zero = (x.mant == 23'h0);
  assign neg       = x.sign;

  always_comb begin
    cls = FP_NORM;
    unique case (1'b1)
      exp_zero && mant_zero:
        cls = FP_ZERO;
      exp_zero && !mant_zero:
        cls = FP_SUB;
      exp_max && mant_zero:
        cls = FP_INF;
      exp_max && x.mant[22]:
        cls = FP_QNAN;
      exp_max && !mant_zero && !x.mant[22]:
        cls = FP_SNAN;
      default:
        cls = FP_NORM;
    endcase
  end

endmodule

// File: rtl/fsub_issue_stage.sv
// Issue stage for the binary32 add/sub core: classify, order, bypass.
// Ports: clk, rst (sync, active high), io (operand in / record out).
module fsub_issue_stage
  import fp32_pkg::*;
#(
  parameter bit FTZ       = 1'b1,
  parameter int MAX_ALIGN = 25
) (
  input logic clk,
  input logic rst,
  fsub_issue_stage_if.slave io
);

  localparam logic [8:0] ALIGN_LIM = 9'(MAX_ALIGN);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } buf_state_e;

  fp32_t     a_raw;
  fp32_t     b_raw;
  fp_class_e a_cls;
  fp_class_e b_cls;
  logic      a_neg;
  logic      b_neg;

  assign a_raw = io.in_a;
  assign b_raw = io.in_b;

  fp32_classify u_cls_a (
    .x   (a_raw),
    .cls (a_cls),
    .neg (a_neg)
  );

  fp32_classify u_cls_b (
    .x   (b_raw),
    .cls (b_cls),
    .neg (b_neg)
  );

  logic sb_eff;
  logic eff_sub;
  logic a_zero;
  logic b_zero;
  logic a_inf;
  logic b_inf;
  logic any_nan;
  logic any_snan;

  assign sb_eff   = b_neg ^ io.in_op;
  assign eff_sub  = a_neg ^ sb_eff;
  assign a_zero   = is_zero(a_cls);
  assign b_zero   = is_zero(b_cls);
  assign a_inf    = (a_cls == FP_INF);
  assign b_inf    = (b_cls == FP_INF);
  assign any_nan  = is_nan(a_cls) | is_nan(b_cls);
  assign any_snan = (a_cls == FP_SNAN)
                  | (b_cls == FP_SNAN);

  // B carries its effective sign from here on;
  // with FTZ a subnormal collapses to signed zero.
  fp32_t a_op;
  fp32_t b_op;

  always_comb begin
    a_op = a_raw;
    b_op = '{
      sign: sb_eff,
      exp:  b_raw.exp,
      mant: b_raw.mant
    };
    if (FTZ && (a_cls == FP_SUB)) begin
      a_op.mant = '0;
    end
    if (FTZ && (b_cls == FP_SUB)) begin
      b_op.mant = '0;
    end
  end

  logic  a_ge;
  logic  mag_eq;
  fp32_t big;
  fp32_t lit;
  logic  [8:0] exp_gap;

  assign a_ge   = {a_op.exp, a_op.mant}
               >= {b_op.exp, b_op.mant};
  assign mag_eq = {a_op.exp, a_op.mant}
               == {b_op.exp, b_op.mant};
  assign big    = a_ge ? a_op : b_op;
  assign lit    = a_ge ? b_op : a_op;

  // big never has the smaller exponent
  assign exp_gap = {1'b0, big.exp}
                 - {1'b0, lit.exp};

  logic  byp;
  logic  inv;
  fp32_t byp_val;

  always_comb begin
    byp     = 1'b1;
    inv     = 1'b0;
    byp_val = POS_ZERO;
    if (any_nan) begin
      byp_val = QNAN;
      inv     = any_snan;
    end else if (a_inf && b_inf && eff_sub) begin
      byp_val = QNAN;
      inv     = 1'b1;
    end else if (a_inf) begin
      byp_val = a_op;
    end else if (b_inf) begin
      byp_val = b_op;
    end else if (a_zero && b_zero) begin
      byp_val      = POS_ZERO;
      byp_val.sign = !eff_sub && a_neg && sb_eff;
    end else if (a_zero) begin
      byp_val = b_op;
    end else if (b_zero) begin
      byp_val = a_op;
    end else if (eff_sub && mag_eq) begin
      byp_val = POS_ZERO;
    end else if (exp_gap > ALIGN_LIM) begin
      byp_val = big;
    end else begin
      byp = 1'b0;
    end
  end

  issue_t new_rec;

  always_comb begin
    new_rec             = '0;
    new_rec.core_a      = big;
    new_rec.core_b      = lit;
    new_rec.core_b.sign = big.sign;
    new_rec.eff_sub     = eff_sub;
    new_rec.bypass      = byp;
    new_rec.bypass_val  = byp_val;
    new_rec.invalid     = inv;
  end

  buf_state_e state_q;
  buf_state_e state_d;
  logic       in_ready_q;
  issue_t     out_q;
  issue_t     skid_q;
  logic       in_xfer;
  logic       out_xfer;
  logic       ld_new;
  logic       ld_skid;
  logic       ld_from_skid;

  assign in_xfer  = io.in_valid & in_ready_q;
  assign out_xfer = (state_q != S_EMPTY)
                  & io.out_ready;

  always_comb begin
    state_d      = state_q;
    ld_new       = 1'b0;
    ld_skid      = 1'b0;
    ld_from_skid = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (in_xfer) begin
          state_d = S_ONE;
          ld_new  = 1'b1;
        end
      end
      S_ONE: begin
        if (in_xfer && out_xfer) begin
          ld_new = 1'b1;
        end else if (in_xfer) begin
          state_d = S_TWO;
          ld_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_xfer) begin
          state_d      = S_ONE;
          ld_from_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_TWO);
      if (ld_new) begin
        out_q <= new_rec;
      end else if (ld_from_skid) begin
        out_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= new_rec;
      end
    end
  end

  assign io.in_ready       = in_ready_q;
  assign io.out_valid      = (state_q != S_EMPTY);
  assign io.out_core_a     = out_q.core_a;
  assign io.out_core_b     = out_q.core_b;
  assign io.out_eff_sub    = out_q.eff_sub;
  assign io.out_bypass     = out_q.bypass;
  assign io.out_bypass_val = out_q.bypass_val;
  assign io.out_invalid    = out_q.invalid;

endmodule
